// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED counter controller: opcodes, FSM state encoding and
// small helpers used by the top level.
package led_ctrl_pkg;

  // Width of the state_o port and of the state encoding.
  localparam int unsigned STATE_W = 2;

  // Width of the command opcode.
  localparam int unsigned OP_W = 3;

  // Command opcodes; 6 and 7 are illegal and only raise err.
  localparam logic [OP_W-1:0] OP_STOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_UP     = 3'd1;
  localparam logic [OP_W-1:0] OP_DOWN   = 3'd2;
  localparam logic [OP_W-1:0] OP_PAUSE  = 3'd3;
  localparam logic [OP_W-1:0] OP_RESUME = 3'd4;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'd5;

  // Encoding is visible on state_o, so the values are fixed explicitly.
  typedef enum logic [STATE_W-1:0] {
    StIdle    = 2'd0,
    StRunUp   = 2'd1,
    StRunDown = 2'd2,
    StPaused  = 2'd3
  } state_e;

  // True in the two states where the prescaler counts and the counter steps.
  function automatic logic is_running(state_e s);
    return (s == StRunUp) || (s == StRunDown);
  endfunction

  // Restore the run state remembered at PAUSE (dir_down = 1 means counting down).
  function automatic state_e run_state(logic dir_down);
    return dir_down ? StRunDown : StRunUp;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step-rate prescaler: counts 0..DIV-1 while running and emits a tick at DIV-1.
// clr forces zero, hold freezes the count (used across PAUSE/RESUME), and the count
// collapses to zero whenever the block is neither running nor holding.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  // At least one bit so DIV=1 still elaborates; the count then stays at 0 and ticks always.
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick = run && (pre_q == LAST);

  // Next prescaler value; clr has priority so LOAD/UP/DOWN restart even while paused.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (hold) begin
      pre_d = pre_q;
    end else if (run) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end else begin
      pre_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/led_count_ctrl.sv
// Command-driven LED counter controller. Accepts one command per two clocks over a
// valid/ready handshake, runs a run/pause/direction FSM and steps an up/down counter
// whose value drives the LEDs directly.
module led_count_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned DIV      = 4,
  parameter bit          ONE_SHOT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [CNT_W-1:0]   cmd_data,
  output logic [CNT_W-1:0]   led,
  output logic [STATE_W-1:0] state_o,
  output logic               wrap,
  output logic               err
);

  state_e           state_q, state_d;
  logic             dir_down_q, dir_down_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic accept;
  logic running;
  logic tick;
  logic pre_clr;
  logic pre_hold;
  logic step_en;
  logic at_wrap;

  assign accept  = cmd_valid && ready_q;
  assign running = is_running(state_q);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (running),
    .clr   (pre_clr),
    .hold  (pre_hold),
    .tick  (tick)
  );

  // Command decode: an accepted command overrides the step that a tick would cause,
  // except for illegal opcodes and ignored PAUSE/RESUME, which let the step proceed.
  always_comb begin
    state_d    = state_q;
    dir_down_d = dir_down_q;
    err_d      = 1'b0;
    pre_clr    = 1'b0;
    pre_hold   = (state_q == StPaused);
    step_en    = tick;
    cnt_d      = cnt_q;
    if (accept) begin
      unique case (cmd_op)
        OP_STOP: begin
          state_d = StIdle;
          cnt_d   = '0;
          pre_clr = 1'b1;
          step_en = 1'b0;
        end
        OP_UP: begin
          state_d = StRunUp;
          pre_clr = 1'b1;
          step_en = 1'b0;
        end
        OP_DOWN: begin
          state_d = StRunDown;
          pre_clr = 1'b1;
          step_en = 1'b0;
        end
        OP_PAUSE: begin
          // A PAUSE on a tick edge freezes the prescaler at DIV-1 so RESUME steps at once.
          if (running) begin
            state_d    = StPaused;
            dir_down_d = (state_q == StRunDown);
            pre_hold   = 1'b1;
            step_en    = 1'b0;
          end
        end
        OP_RESUME: begin
          if (state_q == StPaused) begin
            state_d = run_state(dir_down_q);
          end
        end
        OP_LOAD: begin
          cnt_d   = cmd_data;
          pre_clr = 1'b1;
          step_en = 1'b0;
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  // Counter step and wrap detection; tick only fires in a run state.
  always_comb begin
    wrap_d  = 1'b0;
    at_wrap = 1'b0;
    if (step_en) begin
      if (state_q == StRunDown) begin
        at_wrap = (cnt_q == '0);
      end else begin
        at_wrap = &cnt_q;
      end
      wrap_d = at_wrap;
    end
  end

  // Final counter/state next values once the step decision is known.
  logic [CNT_W-1:0] cnt_next;
  state_e           state_next;

  always_comb begin
    cnt_next   = cnt_d;
    state_next = state_d;
    if (step_en) begin
      cnt_next = (state_q == StRunDown) ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
      if (at_wrap && ONE_SHOT) begin
        state_next = StIdle;
      end
    end
  end

  // Ready drops for the single cycle after every accept.
  always_comb begin
    ready_d = !accept;
  end

  // FSM state and remembered direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      dir_down_q <= 1'b0;
    end else begin
      state_q    <= state_next;
      dir_down_q <= dir_down_d;
    end
  end

  // LED counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_next;
    end
  end

  // Handshake ready and one-cycle event pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign led       = cnt_q;
  assign state_o   = state_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_led_count_ctrl.sv
// Directed bench for led_count_ctrl: a cycle table for the default configuration, plus
// hand-written sequences for ONE_SHOT, DIV=1, back-to-back valid and async reset.
module tb_led_count_ctrl;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;

  logic       rdy, wrp, er;
  logic [3:0] led;
  logic [1:0] st;

  logic       os_rdy, os_wrp, os_er;
  logic [3:0] os_led;
  logic [1:0] os_st;

  logic       d1_rdy, d1_wrp, d1_er;
  logic [3:0] d1_led;
  logic [1:0] d1_st;

  int checks = 0;
  int errors = 0;

  led_count_ctrl #(.CNT_W(4), .DIV(4), .ONE_SHOT(1'b0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .led(led), .state_o(st), .wrap(wrp), .err(er)
  );

  led_count_ctrl #(.CNT_W(4), .DIV(4), .ONE_SHOT(1'b1)) dut_os (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(os_rdy), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .led(os_led), .state_o(os_st), .wrap(os_wrp), .err(os_er)
  );

  led_count_ctrl #(.CNT_W(4), .DIV(1), .ONE_SHOT(1'b0)) dut_d1 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(d1_rdy), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .led(d1_led), .state_o(d1_st), .wrap(d1_wrp), .err(d1_er)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [2:0] op;
    logic [3:0] data;
    logic [7:0] ncyc;
    logic [3:0] led;
    logic [1:0] st;
    logic       wrap;
    logic       err;
    logic       rdy;
  } vec_t;

  localparam int NVEC = 45;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic vld, logic [2:0] op, logic [3:0] data, logic [7:0] ncyc,
                              logic [3:0] l, logic [1:0] s, logic w, logic e, logic r);
    vec_t v;
    v.vld = vld; v.op = op; v.data = data; v.ncyc = ncyc;
    v.led = l; v.st = s; v.wrap = w; v.err = e; v.rdy = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for ready, then presents one command for exactly one edge.
  task automatic send(input logic [2:0] op, input logic [3:0] data);
    int n = 0;
    while (rdy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("send_ready", rdy, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    // vld op data ncyc | led st wrap err rdy
    vecs[0]  = mk(1, 1, 0, 1,   0, 1, 0, 0, 0);  // UP
    vecs[1]  = mk(0, 0, 0, 3,   0, 1, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 1,   1, 1, 0, 0, 1);  // first step at E+4
    vecs[3]  = mk(0, 0, 0, 4,   2, 1, 0, 0, 1);  // second at E+8
    vecs[4]  = mk(1, 5, 14, 1, 14, 1, 0, 0, 0);  // LOAD 14
    vecs[5]  = mk(0, 0, 0, 4,  15, 1, 0, 0, 1);
    vecs[6]  = mk(0, 0, 0, 4,   0, 1, 1, 0, 1);  // 15 -> 0 wrap
    vecs[7]  = mk(0, 0, 0, 1,   0, 1, 0, 0, 1);
    vecs[8]  = mk(1, 2, 0, 1,   0, 2, 0, 0, 0);  // DOWN from 0
    vecs[9]  = mk(0, 0, 0, 4,  15, 2, 1, 0, 1);  // 0 -> 15 wrap
    vecs[10] = mk(0, 0, 0, 2,  15, 2, 0, 0, 1);
    vecs[11] = mk(1, 3, 0, 1,  15, 3, 0, 0, 0);  // PAUSE, prescaler at 2
    vecs[12] = mk(0, 0, 0, 20, 15, 3, 0, 0, 1);  // frozen
    vecs[13] = mk(1, 4, 0, 1,  15, 2, 0, 0, 0);  // RESUME
    vecs[14] = mk(0, 0, 0, 1,  15, 2, 0, 0, 1);
    vecs[15] = mk(0, 0, 0, 1,  14, 2, 0, 0, 1);  // remaining count done, step
    vecs[16] = mk(0, 0, 0, 3,  14, 2, 0, 0, 1);
    vecs[17] = mk(1, 5, 9, 1,   9, 2, 0, 0, 0);  // LOAD on tick edge
    vecs[18] = mk(0, 0, 0, 4,   8, 2, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 3,   8, 2, 0, 0, 1);
    vecs[20] = mk(1, 0, 0, 1,   0, 0, 0, 0, 0);  // STOP on tick edge
    vecs[21] = mk(0, 0, 0, 5,   0, 0, 0, 0, 1);
    vecs[22] = mk(1, 1, 0, 1,   0, 1, 0, 0, 0);  // UP
    vecs[23] = mk(0, 0, 0, 1,   0, 1, 0, 0, 1);
    vecs[24] = mk(1, 7, 0, 1,   0, 1, 0, 1, 0);  // illegal op 7
    vecs[25] = mk(0, 0, 0, 1,   0, 1, 0, 0, 1);
    vecs[26] = mk(0, 0, 0, 1,   1, 1, 0, 0, 1);  // step still happens
    vecs[27] = mk(1, 4, 0, 1,   1, 1, 0, 0, 0);  // RESUME while running: ignored
    vecs[28] = mk(1, 0, 0, 1,   1, 1, 0, 0, 1);  // STOP while not ready: ignored
    vecs[29] = mk(1, 0, 0, 1,   0, 0, 0, 0, 0);  // STOP
    vecs[30] = mk(0, 0, 0, 1,   0, 0, 0, 0, 1);
    vecs[31] = mk(1, 4, 0, 1,   0, 0, 0, 0, 0);  // RESUME in IDLE
    vecs[32] = mk(0, 0, 0, 1,   0, 0, 0, 0, 1);
    vecs[33] = mk(1, 6, 0, 1,   0, 0, 0, 1, 0);  // illegal op 6
    vecs[34] = mk(0, 0, 0, 1,   0, 0, 0, 0, 1);
    vecs[35] = mk(1, 3, 0, 1,   0, 0, 0, 0, 0);  // PAUSE in IDLE
    vecs[36] = mk(0, 0, 0, 1,   0, 0, 0, 0, 1);
    vecs[37] = mk(1, 5, 5, 1,   5, 0, 0, 0, 0);  // LOAD in IDLE
    vecs[38] = mk(0, 0, 0, 10,  5, 0, 0, 0, 1);  // no stepping in IDLE
    vecs[39] = mk(1, 1, 0, 1,   5, 1, 0, 0, 0);  // UP
    vecs[40] = mk(0, 0, 0, 3,   5, 1, 0, 0, 1);
    vecs[41] = mk(1, 3, 0, 1,   5, 3, 0, 0, 0);  // PAUSE on tick edge
    vecs[42] = mk(0, 0, 0, 5,   5, 3, 0, 0, 1);
    vecs[43] = mk(1, 4, 0, 1,   5, 1, 0, 0, 0);  // RESUME
    vecs[44] = mk(0, 0, 0, 1,   6, 1, 0, 0, 1);  // steps on first running edge

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    step();
    step();
    chk("rst_ready", rdy, 0);
    chk("rst_led", led, 0);
    chk("rst_state", st, 0);
    chk("rst_wrap", wrp, 0);
    chk("rst_err", er, 0);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_rel_ready_low", rdy, 0);
    step();
    chk("rst_rel_ready", rdy, 1);

    for (int i = 0; i < NVEC; i++) begin
      cmd_valid = vecs[i].vld;
      cmd_op    = vecs[i].op;
      cmd_data  = vecs[i].data;
      step();
      cmd_valid = 1'b0;
      for (int k = 1; k < int'(vecs[i].ncyc); k++) step();
      chk($sformatf("vec%0d_led", i), led, vecs[i].led);
      chk($sformatf("vec%0d_state", i), st, vecs[i].st);
      chk($sformatf("vec%0d_wrap", i), wrp, vecs[i].wrap);
      chk($sformatf("vec%0d_err", i), er, vecs[i].err);
      chk($sformatf("vec%0d_ready", i), rdy, vecs[i].rdy);
    end

    // Valid held high with a fresh LOAD value every clock: only every 2nd is taken.
    for (int i = 0; i < 8; i++) begin
      logic [3:0] d;
      d = 4'(i);
      cmd_valid = 1'b1;
      cmd_op    = 3'd5;
      cmd_data  = d;
      step();
      chk($sformatf("stream%0d_led", i), led, (i % 2 == 0) ? i : i - 1);
      chk($sformatf("stream%0d_ready", i), rdy, (i % 2 == 1) ? 1 : 0);
    end
    cmd_valid = 1'b0;

    // ONE_SHOT: the first wrap returns to IDLE and leaves the counter at 0.
    send(3'd0, 4'd0);
    send(3'd5, 4'd14);
    send(3'd1, 4'd0);
    repeat (4) step();
    chk("os_led15", os_led, 15);
    chk("os_state_run", os_st, 1);
    repeat (4) step();
    chk("os_led_wrap", os_led, 0);
    chk("os_wrap", os_wrp, 1);
    chk("os_state_idle", os_st, 0);
    chk("main_state_still_run", st, 1);
    chk("main_wrap", wrp, 1);
    repeat (8) step();
    chk("os_led_held", os_led, 0);
    chk("os_state_held", os_st, 0);
    chk("os_wrap_once", os_wrp, 0);

    // DIV=1: a step on every running edge.
    send(3'd0, 4'd0);
    send(3'd1, 4'd0);
    chk("d1_led0", d1_led, 0);
    chk("d1_state", d1_st, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("d1_led%0d", i), d1_led, i);
    end

    // Asynchronous reset between edges while running.
    send(3'd5, 4'd9);
    send(3'd1, 4'd0);
    step();
    step();
    chk("pre_rst_led", led, 9);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_led", led, 0);
    chk("arst_state", st, 0);
    chk("arst_ready", rdy, 0);
    chk("arst_wrap", wrp, 0);
    chk("arst_err", er, 0);
    step();
    chk("arst_hold_ready", rdy, 0);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_rel_ready_low", rdy, 0);
    step();
    chk("arst_rel_ready", rdy, 1);
    chk("arst_rel_led", led, 0);
    chk("arst_rel_state", st, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
